// File: rtl/wb_sram_burst_slave.sv
// Wishbone B4 registered-feedback SRAM slave with classic, linear and wrap-4/8/16 bursts.
// First ACK/ERR 1 cycle after STB, then 1 beat/cycle; STB low parks in STALL, CYC low returns to IDLE.
module wb_sram_burst_slave #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       WE,
    output logic                       ACK,
    output logic                       ERR
);
    localparam int NB    = WB_DATA_WIDTH / 8;
    localparam int BSH   = $clog2(NB);
    localparam int DEPTH = 2 ** MEM_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, BEAT, STALL} state_t;

    state_t                     state;
    logic [WB_DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [MEM_ADDR_BITS-1:0]   baddr;
    logic [MEM_ADDR_BITS-1:0]   nxt_addr;
    logic [MEM_ADDR_BITS-1:0]   wrap_mask;
    logic [MEM_ADDR_BITS-1:0]   start_idx;
    logic [WB_ADDR_WIDTH-1:0]   offset;
    logic [WB_ADDR_WIDTH-1:0]   widx_full;
    logic                       in_range;
    logic                       ack_r;
    logic                       err_r;

    assign offset    = ADR - ADDR_BASE;
    assign widx_full = offset >> BSH;
    assign in_range  = (ADR >= ADDR_BASE) && ((widx_full >> MEM_ADDR_BITS) == '0);
    assign start_idx = widx_full[MEM_ADDR_BITS-1:0];

    // Bits under the mask count modulo N; bits above it are held. Linear uses an all-ones mask.
    always_comb begin
        wrap_mask = '1;
        case (BTE)
            2'b01:   wrap_mask = MEM_ADDR_BITS'(3);
            2'b10:   wrap_mask = MEM_ADDR_BITS'(7);
            2'b11:   wrap_mask = MEM_ADDR_BITS'(15);
            default: wrap_mask = '1;
        endcase
    end

    assign nxt_addr = (baddr & ~wrap_mask) | ((baddr + MEM_ADDR_BITS'(1)) & wrap_mask);

    assign ACK = ack_r & CYC & STB;
    assign ERR = err_r & CYC & STB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            baddr <= '0;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            DAT_R <= '0;
        end else if (!CYC) begin
            state <= IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (STB) begin
                        state <= BEAT;
                        baddr <= start_idx;
                        if (in_range) begin
                            DAT_R <= mem[start_idx];
                            ack_r <= 1'b1;
                        end else begin
                            DAT_R <= '0;
                            err_r <= 1'b1;
                        end
                    end
                end
                BEAT: begin
                    // In BEAT exactly one of ack_r/err_r is set, so a strobe here completes a beat.
                    if (STB) begin
                        if (err_r || CTI != 3'b010) begin
                            state <= IDLE;
                            ack_r <= 1'b0;
                            err_r <= 1'b0;
                        end else begin
                            baddr <= nxt_addr;
                            DAT_R <= mem[nxt_addr];
                        end
                    end else if (!err_r) begin
                        ack_r <= 1'b0;
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (STB) begin
                        DAT_R <= mem[baddr];
                        ack_r <= 1'b1;
                        state <= BEAT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes only on a gated ACK, so a reset or CYC drop mid-beat never commits data.
    always_ff @(posedge clk) begin
        if (ACK && WE) begin
            for (int b = 0; b < NB; b++) begin
                if (SEL[b]) mem[baddr][b*8 +: 8] <= DAT_W[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Directed bench for wb_sram_burst_slave with a read-data scoreboard and a word-level memory model.
module tb_wb_sram_burst_slave;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ADR, DAT_W, DAT_R;
    logic [2:0]  CTI;
    logic [1:0]  BTE;
    logic        CYC, STB, WE, ACK, ERR;
    logic [3:0]  SEL;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [0:DEPTH-1];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    wb_sram_burst_slave #(
        .WB_ADDR_WIDTH(32),
        .WB_DATA_WIDTH(32),
        .MEM_ADDR_BITS(10),
        .ADDR_BASE    (BASE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ADR  (ADR),
        .CTI  (CTI),
        .BTE  (BTE),
        .DAT_W(DAT_W),
        .DAT_R(DAT_R),
        .CYC  (CYC),
        .STB  (STB),
        .SEL  (SEL),
        .WE   (WE),
        .ACK  (ACK),
        .ERR  (ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int a, input logic [1:0] bte);
        int n;
        case (bte)
            2'b01:   n = 4;
            2'b10:   n = 8;
            2'b11:   n = 16;
            default: n = DEPTH;
        endcase
        return (a / n) * n + ((a % n) + 1) % n;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle of n beats starting at word widx0; STB drops for stall_len cycles before beat stall_at.
    task automatic burst(input string tag, input int widx0, input bit we, input int n,
                         input logic [1:0] bte, input logic [3:0] sel, input logic [31:0] wbase,
                         input int stall_at, input int stall_len);
        int          beat = 0;
        int          widx = widx0;
        int          stalled = 0;
        int          guard = 0;
        bit          need_wait = 1'b1;
        bit          pushed = 1'b0;
        logic        exp_ack;
        logic [31:0] m;
        ADR = BASE + 32'(widx0 * 4);
        CYC = 1'b1;
        WE  = we;
        SEL = sel;
        BTE = bte;
        while (beat < n && guard < n + stall_len + 4) begin
            guard++;
            if (beat == stall_at && stalled < stall_len) begin
                STB = 1'b0;
                stalled++;
                need_wait = 1'b1;
                exp_ack = 1'b0;
            end else begin
                STB = 1'b1;
                if (!pushed) begin
                    if (!we) exp_q.push_back(model[widx]);
                    pushed = 1'b1;
                end
                exp_ack = !need_wait;
            end
            CTI   = (n == 1) ? 3'b000 : ((beat == n - 1) ? 3'b111 : 3'b010);
            DAT_W = wbase + 32'(beat);
            #3;
            chk({tag, " ack"}, 32'(ACK), 32'(exp_ack));
            chk({tag, " err"}, 32'(ERR), 32'd0);
            if (ACK === 1'b1) begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) model[widx][b*8 +: 8] = DAT_W[b*8 +: 8];
                end else begin
                    m = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                    chk({tag, " data"}, DAT_R, m);
                end
                beat++;
                widx = nxt(widx, bte);
                pushed = 1'b0;
            end
            if (STB) need_wait = 1'b0;
            next_cycle();
        end
        chk({tag, " beats"}, 32'(beat), 32'(n));
        CYC = 1'b0;
        STB = 1'b0;
        WE  = 1'b0;
        #3;
        chk({tag, " idle ack"}, 32'(ACK), 32'd0);
        next_cycle();
        exp_q.delete();
    endtask

    task automatic err_access(input string tag, input logic [31:0] addr, input bit we);
        ADR = addr; CYC = 1'b1; STB = 1'b1; WE = we; SEL = 4'hF; CTI = 3'b000;
        DAT_W = 32'hBAD0_BAD0;
        #3;
        chk({tag, " err0"}, 32'(ERR), 32'd0);
        next_cycle();
        #3;
        chk({tag, " ack"}, 32'(ACK), 32'd0);
        chk({tag, " err"}, 32'(ERR), 32'd1);
        chk({tag, " dat"}, DAT_R, 32'd0);
        next_cycle();
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        #3;
        chk({tag, " err end"}, 32'(ERR), 32'd0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = '0; SEL = '0;
        CTI = '0; BTE = '0; DAT_W = '0;
        repeat (2) @(posedge clk);
        #1;
        CYC = 1'b1; STB = 1'b1; ADR = BASE;
        #3;
        chk("reset ack", 32'(ACK), 32'd0);
        chk("reset err", 32'(ERR), 32'd0);
        chk("reset dat", DAT_R, 32'd0);
        CYC = 1'b0; STB = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        burst("preload", 0, 1'b1, 16, 2'b00, 4'hF, 32'h1000_0000, -1, 0);
        burst("last_wr", 1023, 1'b1, 1, 2'b00, 4'hF, 32'hCAFE_0000, -1, 0);

        burst("t1_wr", 4, 1'b1, 1, 2'b00, 4'hF, 32'hDEAD_BEEF, -1, 0);
        burst("t1_rd", 4, 1'b0, 1, 2'b00, 4'hF, 32'h0, -1, 0);

        burst("t2_full", 8, 1'b1, 1, 2'b00, 4'hF, 32'h1122_3344, -1, 0);
        burst("t2_byte", 8, 1'b1, 1, 2'b00, 4'b0001, 32'h0000_00AA, -1, 0);
        burst("t2_rd", 8, 1'b0, 1, 2'b00, 4'hF, 32'h0, -1, 0);
        chk("t2 model", model[8], 32'h1122_33AA);
        burst("t2_sel0", 8, 1'b1, 1, 2'b00, 4'b0000, 32'h5555_5555, -1, 0);
        burst("t2_sel0_rd", 8, 1'b0, 1, 2'b00, 4'hF, 32'h0, -1, 0);

        burst("wrap4", 6, 1'b0, 4, 2'b01, 4'hF, 32'h0, -1, 0);
        burst("wrap8", 13, 1'b0, 5, 2'b10, 4'hF, 32'h0, -1, 0);
        burst("wrap16", 14, 1'b0, 4, 2'b11, 4'hF, 32'h0, -1, 0);

        burst("lin_stall", 0, 1'b0, 5, 2'b00, 4'hF, 32'h0, 2, 2);
        burst("lin_end", 1023, 1'b0, 2, 2'b00, 4'hF, 32'h0, -1, 0);
        burst("wr_stall", 10, 1'b1, 3, 2'b01, 4'hF, 32'h7700_0000, 1, 1);
        burst("wr_stall_rd", 8, 1'b0, 4, 2'b01, 4'hF, 32'h0, -1, 0);

        err_access("oor_hi_rd", BASE + 32'h1000, 1'b0);
        err_access("oor_hi_wr", BASE + 32'h1000, 1'b1);
        err_access("oor_lo_wr", BASE - 32'd4, 1'b1);
        burst("oor_chk0", 0, 1'b0, 1, 2'b00, 4'hF, 32'h0, -1, 0);
        burst("oor_chk1023", 1023, 1'b0, 1, 2'b00, 4'hF, 32'h0, -1, 0);

        // Reset lands while a write beat is being acknowledged; that beat must not reach memory.
        ADR = BASE; CYC = 1'b1; STB = 1'b1; WE = 1'b1; SEL = 4'hF;
        CTI = 3'b010; BTE = 2'b00; DAT_W = 32'h5A5A_5A5A;
        next_cycle();
        #2;
        chk("rst_mid pre ack", 32'(ACK), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid ack", 32'(ACK), 32'd0);
        chk("rst_mid err", 32'(ERR), 32'd0);
        chk("rst_mid dat", DAT_R, 32'd0);
        next_cycle();
        rst = 1'b0; CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        next_cycle();
        burst("post_rst", 0, 1'b0, 2, 2'b00, 4'hF, 32'h0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_sram_burst_slave.md
Name: wb_sram_burst_slave

Overview:
- Single-port Wishbone B4 registered-feedback SRAM slave that sits directly downstream of the wb_interconnect slave ports. It consumes one slave-side channel: SADR/SCTI/SBTE/SDAT_W/SCYC/SSEL/SSTB/SWE, and returns SDAT_R/SACK/SERR.
- Supports classic single cycles plus incrementing bursts with linear, wrap-4, wrap-8 and wrap-16 modes, at one beat per cycle in steady state.
- Intended as the on-chip RAM behind an interconnect address window.

Parameters:
- WB_ADDR_WIDTH, 32, address bus width in bits.
- WB_DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- MEM_ADDR_BITS, 10, word-index width; memory depth is 2**MEM_ADDR_BITS words.
- ADDR_BASE, 'h0, byte address of word 0; must be aligned to the memory size.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  asynchronous active-high reset.
- ADR  input  WB_ADDR_WIDTH  byte address; sampled only on the first beat.
- CTI  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; other codes are treated as classic.
- BTE  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- DAT_W  input  WB_DATA_WIDTH  write data.
- DAT_R  output  WB_DATA_WIDTH  read data, registered.
- CYC  input  1  bus cycle active.
- STB  input  1  strobe.
- SEL  input  WB_DATA_WIDTH/8  byte enables.
- WE  input  1  write enable.
- ACK  output  1  beat acknowledge.
- ERR  output  1  beat error, for an address outside the memory window.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: ACK=0, ERR=0, DAT_R=0, state=IDLE, internal beat address=0. Memory contents are not reset. An assertion of rst mid-burst clears the outputs immediately, with no partial write of the current beat.
- Word index: widx = (ADR-ADDR_BASE) >> log2(WB_DATA_WIDTH/8). The address is in range iff ADR >= ADDR_BASE and widx < 2**MEM_ADDR_BITS.
- State machine states: IDLE, BEAT, STALL.
- IDLE:
  - On CYC&STB, latch widx into baddr, read mem[widx] into DAT_R, and go to BEAT with ack_r=1.
  - If the address is out of range, set err_r=1 instead of ack_r, set DAT_R=0, and go to BEAT.
  - Latency from the first strobe to ACK/ERR is 1 cycle.
- Output gating: ACK = ack_r & CYC & STB, and ERR = err_r & CYC & STB. No acknowledge is ever driven while the master is not strobing.
- Write: on any cycle with ACK=1 and WE=1, mem[baddr] is byte-written with DAT_W under SEL. A SEL=0 beat is acked with no change to memory.
- BEAT, when ACK or ERR is asserted, the beat completes:
  - If err_r, or CTI is not 010, or CYC=0: go to IDLE with ack_r=0 and err_r=0. IDLE enforces at least one idle cycle between classic cycles.
  - Else (incrementing burst): baddr <= nxt(baddr), DAT_R <= mem[nxt] (read-before-write is not required because the addresses differ), ack_r stays 1, and the state stays BEAT. Throughput is 1 beat/cycle.
- BEAT with CYC=1 and STB=0 (master wait state): ack_r <= 0 and go to STALL, holding baddr.
- STALL:
  - When STB returns with CYC=1, reload DAT_R <= mem[baddr], set ack_r=1 and go to BEAT (1-cycle latency).
  - On CYC=0, go to IDLE.
- CYC=0 in any state: go to IDLE next cycle. Outputs are already masked combinationally.
- nxt(a) by BTE:
  - linear: (a+1) mod 2**MEM_ADDR_BITS, i.e. wrap-around at the end of memory with no ERR.
  - wrapN: the low log2(N) bits increment modulo N and the upper bits are held.
- The ADR of beats after the first is ignored. CTI and BTE are sampled on each completing beat.
- Simultaneous CYC drop and ACK: the beat is not acked (gated), so no write occurs.

Test Plan:
1. Classic write then read: write 'hDEADBEEF to ADDR_BASE+'h10 with SEL=1111, then read the same address. Each ACK appears 1 cycle after STB, and the read returns 'hDEADBEEF with 1 ACK per cycle.
2. Byte-lane write: write 'h000000AA with SEL=0001 over 'h11223344. A read then returns 'h112233AA.
3. Wrap-4 read burst from word 6 (CTI=010,010,010,111): 4 consecutive ACK cycles return words 6,7,4,5, then ACK=0 and state IDLE.
4. Linear burst with a wait: STB=0 for 2 cycles after beat 2 gives ACK=0 during the stall. ACK resumes 1 cycle after STB returns, with the correct beat-3 data; a final 111 beat ends the burst. Also cover a linear burst from the last word, whose next beat reads word 0.
5. Out-of-range: a classic read at ADDR_BASE+(4<<MEM_ADDR_BITS) gives ERR for one cycle, ACK=0, DAT_R=0, and no memory change. Assert rst mid-burst: ACK/ERR/DAT_R are 0 in the same cycle and the next CYC starts a fresh first beat.
